// File: rtl/pipeline_pkg.sv
// Shared pipeline types: forwarding selects, hazard FSM states and a
// register-match helper used by the operand forwarding comparators.
package pipeline_pkg;

  localparam int REG_W = 5;

  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_EX  = 2'd1,
    FWD_MEM = 2'd2,
    FWD_WB  = 2'd3
  } fwd_sel_t;

  typedef enum logic {
    HZ_RUN     = 1'b0,
    HZ_EX_BUSY = 1'b1
  } hz_state_t;

  // A stage can supply an operand only if it really writes a nonzero register
  function automatic logic reg_match(input logic valid, input logic w_rd,
                                     input logic [REG_W-1:0] rd,
                                     input logic [REG_W-1:0] rs);
    return valid & w_rd & (rd != 5'd0) & (rd == rs);
  endfunction

endpackage

// File: rtl/fwd_unit.sv
// Per-operand forwarding priority comparator: youngest producer wins,
// except a load still in EX, whose data does not exist yet.
module fwd_unit import pipeline_pkg::*; (
  input  logic [REG_W-1:0] rs,
  input  logic             ex_valid,
  input  logic             ex_w_rd,
  input  logic             ex_is_load,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             mem_valid,
  input  logic             mem_w_rd,
  input  logic [REG_W-1:0] mem_rd,
  input  logic             wb_valid,
  input  logic             wb_w_rd,
  input  logic [REG_W-1:0] wb_rd,
  output fwd_sel_t         sel
);

  // Priority select EX > MEM > WB > register file
  always_comb begin
    sel = FWD_RF;
    if (rs == 5'd0) begin
      sel = FWD_RF;
    end else if (reg_match(ex_valid, ex_w_rd, ex_rd, rs) & !ex_is_load) begin
      sel = FWD_EX;
    end else if (reg_match(mem_valid, mem_w_rd, mem_rd, rs)) begin
      sel = FWD_MEM;
    end else if (reg_match(wb_valid, wb_w_rd, wb_rd, rs)) begin
      sel = FWD_WB;
    end else begin
      sel = FWD_RF;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Central stall/flush/forwarding controller for the 5-stage pipeline:
// multi-cycle EX sequencing, load-use interlock and fetch redirect hold.
module hazard_ctrl import pipeline_pkg::*; #(
  parameter int MC_LAT = 4,
  parameter int XLEN   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             ex_valid,
  input  logic             ex_w_rd,
  input  logic             ex_is_load,
  input  logic             ex_mc_start,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_branch,
  input  logic [XLEN-1:0]  ex_branch_dest,
  input  logic             mem_valid,
  input  logic             mem_w_rd,
  input  logic [REG_W-1:0] mem_rd,
  input  logic             wb_valid,
  input  logic             wb_w_rd,
  input  logic [REG_W-1:0] wb_rd,
  input  logic             imem_ready,
  input  logic             dmem_req,
  input  logic             dmem_ack,
  output logic             stall_if,
  output logic             stall_id,
  output logic             stall_ex,
  output logic             stall_mem,
  output logic             bubble_id,
  output logic             bubble_ex,
  output logic             bubble_mem,
  output logic             bubble_wb,
  output logic [1:0]       fwd_op1,
  output logic [1:0]       fwd_op2,
  output logic             redirect,
  output logic [XLEN-1:0]  redirect_pc
);

  localparam int CNT_W = (MC_LAT > 2) ? $clog2(MC_LAT) : 1;
  localparam logic [CNT_W-1:0] MC_INIT = (MC_LAT > 2) ? CNT_W'(MC_LAT - 2) : {CNT_W{1'b0}};
  localparam logic MC_EN = (MC_LAT > 1) ? 1'b1 : 1'b0;

  hz_state_t        state_r;
  logic [CNT_W-1:0] mc_cnt_r;
  logic             rd_pend_r;
  logic [XLEN-1:0]  rd_pc_q_r;

  logic mem_wait_s, mc_start_s, ex_hold_s, take_s, lu_raw_s, load_use_s, imem_wait_s;
  logic stall_id_s, stall_ex_s;
  fwd_sel_t fwd1_s, fwd2_s;

  assign mem_wait_s = mem_valid & dmem_req & !dmem_ack;
  assign mc_start_s = (state_r == HZ_RUN) & ex_valid & ex_mc_start & MC_EN;
  // The final EX_BUSY cycle (count exhausted) lets the op leave EX
  assign ex_hold_s  = mc_start_s | ((state_r == HZ_EX_BUSY) & (mc_cnt_r != {CNT_W{1'b0}}));
  assign stall_ex_s = mem_wait_s | ex_hold_s;
  assign take_s     = ex_valid & ex_branch & !stall_ex_s;
  assign lu_raw_s   = ex_valid & ex_is_load & ex_w_rd & (ex_rd != 5'd0) & id_valid &
                      ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));
  assign load_use_s  = lu_raw_s & !stall_ex_s & !take_s;
  assign stall_id_s  = stall_ex_s | load_use_s;
  assign imem_wait_s = !imem_ready & !stall_id_s & !take_s;

  fwd_unit u_fwd_op1 (
    .rs(id_rs1), .ex_valid(ex_valid), .ex_w_rd(ex_w_rd), .ex_is_load(ex_is_load),
    .ex_rd(ex_rd), .mem_valid(mem_valid), .mem_w_rd(mem_w_rd), .mem_rd(mem_rd),
    .wb_valid(wb_valid), .wb_w_rd(wb_w_rd), .wb_rd(wb_rd), .sel(fwd1_s)
  );

  fwd_unit u_fwd_op2 (
    .rs(id_rs2), .ex_valid(ex_valid), .ex_w_rd(ex_w_rd), .ex_is_load(ex_is_load),
    .ex_rd(ex_rd), .mem_valid(mem_valid), .mem_w_rd(mem_w_rd), .mem_rd(mem_rd),
    .wb_valid(wb_valid), .wb_w_rd(wb_w_rd), .wb_rd(wb_rd), .sel(fwd2_s)
  );

  // Multi-cycle EX sequencer; a stalled MEM freezes it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= HZ_RUN;
      mc_cnt_r <= {CNT_W{1'b0}};
    end else begin
      case (state_r)
        HZ_RUN: begin
          if (mc_start_s & !mem_wait_s) begin
            state_r  <= HZ_EX_BUSY;
            mc_cnt_r <= MC_INIT;
          end
        end
        HZ_EX_BUSY: begin
          if (mem_wait_s) begin
            mc_cnt_r <= mc_cnt_r;
          end else if (mc_cnt_r == {CNT_W{1'b0}}) begin
            state_r <= HZ_RUN;
          end else begin
            mc_cnt_r <= mc_cnt_r - CNT_W'(1);
          end
        end
        default: begin
          state_r  <= HZ_RUN;
          mc_cnt_r <= {CNT_W{1'b0}};
        end
      endcase
    end
  end

  // Redirect latch: park a taken-branch target until fetch can accept it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_pend_r <= 1'b0;
      rd_pc_q_r <= {XLEN{1'b0}};
    end else if (take_s) begin
      rd_pend_r <= !imem_ready;
      if (!imem_ready) begin
        rd_pc_q_r <= ex_branch_dest;
      end
    end else if (rd_pend_r & imem_ready) begin
      rd_pend_r <= 1'b0;
    end
  end

  // Output drive; reset forces every stage to take a bubble
  always_comb begin
    stall_if    = 1'b0;
    stall_id    = 1'b0;
    stall_ex    = 1'b0;
    stall_mem   = 1'b0;
    bubble_id   = 1'b1;
    bubble_ex   = 1'b1;
    bubble_mem  = 1'b1;
    bubble_wb   = 1'b1;
    fwd_op1     = 2'd0;
    fwd_op2     = 2'd0;
    redirect    = 1'b0;
    redirect_pc = {XLEN{1'b0}};
    if (rst) begin
      redirect = 1'b0;
    end else begin
      stall_mem  = mem_wait_s;
      stall_ex   = stall_ex_s;
      stall_id   = stall_id_s;
      stall_if   = stall_id_s | imem_wait_s;
      bubble_id  = (take_s | rd_pend_r | imem_wait_s) & !stall_id_s;
      bubble_ex  = (take_s | load_use_s) & !stall_ex_s;
      bubble_mem = ex_hold_s & !mem_wait_s;
      bubble_wb  = mem_wait_s;
      fwd_op1    = fwd1_s;
      fwd_op2    = fwd2_s;
      redirect   = (take_s | rd_pend_r) & imem_ready;
      if (take_s & imem_ready) begin
        redirect_pc = ex_branch_dest;
      end else begin
        redirect_pc = rd_pc_q_r;
      end
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: priority-rule model checked every
// cycle plus directed vectors with hand-computed expectations.
module tb_hazard_ctrl;

  localparam int MC_LAT = 4;
  localparam int XLEN   = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic id_valid = 1'b0, id_use_rs1 = 1'b0, id_use_rs2 = 1'b0;
  logic [4:0] id_rs1 = 5'd0, id_rs2 = 5'd0, ex_rd = 5'd0, mem_rd = 5'd0, wb_rd = 5'd0;
  logic ex_valid = 1'b0, ex_w_rd = 1'b0, ex_is_load = 1'b0, ex_mc_start = 1'b0, ex_branch = 1'b0;
  logic [XLEN-1:0] ex_branch_dest = 32'd0;
  logic mem_valid = 1'b0, mem_w_rd = 1'b0, wb_valid = 1'b0, wb_w_rd = 1'b0;
  logic imem_ready = 1'b1, dmem_req = 1'b0, dmem_ack = 1'b1;
  logic stall_if, stall_id, stall_ex, stall_mem;
  logic bubble_id, bubble_ex, bubble_mem, bubble_wb;
  logic [1:0] fwd_op1, fwd_op2;
  logic redirect;
  logic [XLEN-1:0] redirect_pc;

  int n_tests = 0;
  int n_fail  = 0;

  hazard_ctrl #(.MC_LAT(MC_LAT), .XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_valid(ex_valid),
    .ex_w_rd(ex_w_rd), .ex_is_load(ex_is_load), .ex_mc_start(ex_mc_start),
    .ex_rd(ex_rd), .ex_branch(ex_branch), .ex_branch_dest(ex_branch_dest),
    .mem_valid(mem_valid), .mem_w_rd(mem_w_rd), .mem_rd(mem_rd),
    .wb_valid(wb_valid), .wb_w_rd(wb_w_rd), .wb_rd(wb_rd),
    .imem_ready(imem_ready), .dmem_req(dmem_req), .dmem_ack(dmem_ack),
    .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex), .stall_mem(stall_mem),
    .bubble_id(bubble_id), .bubble_ex(bubble_ex), .bubble_mem(bubble_mem), .bubble_wb(bubble_wb),
    .fwd_op1(fwd_op1), .fwd_op2(fwd_op2), .redirect(redirect), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic s_if, s_id, s_ex, s_mem;
    logic b_id, b_ex, b_mem, b_wb;
    logic [1:0] f1, f2;
    logic rd;
    logic pc_valid;
    logic take;
    logic [31:0] pc;
  } exp_t;

  // Model state: non-stalled cycles the current multi-cycle op has spent in EX,
  // and the parked redirect target.
  int          m_tenure = 0;
  logic        m_pend   = 1'b0;
  logic [31:0] m_pc     = 32'd0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] fwd_model(input logic [4:0] rs);
    logic [4:0] rds [3];
    logic       ok  [3];
    rds = '{ex_rd, mem_rd, wb_rd};
    ok  = '{ex_valid & ex_w_rd & !ex_is_load, mem_valid & mem_w_rd, wb_valid & wb_w_rd};
    if (rs == 5'd0) return 2'd0;
    for (int k = 0; k < 3; k++) begin
      if (ok[k] && rds[k] == rs) return 2'(k + 1);
    end
    return 2'd0;
  endfunction

  function automatic exp_t model_eval();
    exp_t e;
    logic mw, busy, lu;
    e = '0;
    if (rst) begin
      {e.b_id, e.b_ex, e.b_mem, e.b_wb} = 4'b1111;
      e.pc_valid = 1'b1;
      return e;
    end
    mw   = mem_valid & dmem_req & !dmem_ack;
    busy = ex_valid & ex_mc_start & (MC_LAT > 1) & (m_tenure < MC_LAT - 1);
    e.take = ex_valid & ex_branch & !(mw | busy);
    lu = ex_valid & ex_is_load & ex_w_rd & (ex_rd != 5'd0) & id_valid &
         ((id_use_rs1 & id_rs1 == ex_rd) | (id_use_rs2 & id_rs2 == ex_rd));
    if (mw) begin
      {e.s_if, e.s_id, e.s_ex, e.s_mem, e.b_wb} = 5'b11111;
    end else if (busy) begin
      {e.s_if, e.s_id, e.s_ex, e.b_mem} = 4'b1111;
    end else if (e.take) begin
      {e.b_id, e.b_ex} = 2'b11;
    end else if (lu) begin
      {e.s_if, e.s_id, e.b_ex} = 3'b111;
    end else if (!imem_ready) begin
      {e.s_if, e.b_id} = 2'b11;
    end
    if (m_pend && !e.s_id) e.b_id = 1'b1;
    e.rd = (e.take | m_pend) & imem_ready;
    e.pc = (e.take & imem_ready) ? ex_branch_dest : m_pc;
    e.pc_valid = e.rd | m_pend;
    e.f1 = fwd_model(id_rs1);
    e.f2 = fwd_model(id_rs2);
    return e;
  endfunction

  // Advance the model at each clock edge
  always @(posedge clk or posedge rst) begin
    exp_t e;
    if (rst) begin
      m_tenure = 0; m_pend = 1'b0; m_pc = 32'd0;
    end else begin
      e = model_eval();
      if (!(mem_valid & dmem_req & !dmem_ack)) begin
        if (ex_valid & ex_mc_start & (m_tenure < MC_LAT - 1)) m_tenure = m_tenure + 1;
        else m_tenure = 0;
      end
      if (e.take) begin
        m_pend = !imem_ready;
        if (!imem_ready) m_pc = ex_branch_dest;
      end else if (m_pend & imem_ready) begin
        m_pend = 1'b0;
      end
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    exp_t e;
    e = model_eval();
    chk("m_stall_if", stall_if, e.s_if);
    chk("m_stall_id", stall_id, e.s_id);
    chk("m_stall_ex", stall_ex, e.s_ex);
    chk("m_stall_mem", stall_mem, e.s_mem);
    chk("m_bubble_id", bubble_id, e.b_id);
    chk("m_bubble_ex", bubble_ex, e.b_ex);
    chk("m_bubble_mem", bubble_mem, e.b_mem);
    chk("m_bubble_wb", bubble_wb, e.b_wb);
    chk("m_fwd_op1", fwd_op1, e.f1);
    chk("m_fwd_op2", fwd_op2, e.f2);
    chk("m_redirect", redirect, e.rd);
    if (e.pc_valid) chk("m_redirect_pc", redirect_pc, e.pc);
  end

  task automatic idle();
    id_valid = 1'b0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; id_rs1 = 5'd0; id_rs2 = 5'd0;
    ex_valid = 1'b0; ex_w_rd = 1'b0; ex_is_load = 1'b0; ex_mc_start = 1'b0; ex_rd = 5'd0;
    ex_branch = 1'b0; ex_branch_dest = 32'd0;
    mem_valid = 1'b0; mem_w_rd = 1'b0; mem_rd = 5'd0;
    wb_valid = 1'b0; wb_w_rd = 1'b0; wb_rd = 5'd0;
    imem_ready = 1'b1; dmem_req = 1'b0; dmem_ack = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic settle();
    @(negedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_bubble_wb", bubble_wb, 1'b1);
    chk("rst_bubble_id", bubble_id, 1'b1);
    chk("rst_stall_if", stall_if, 1'b0);
    chk("rst_redirect", redirect, 1'b0);
    rst = 1'b0;
    settle();
    chk("idle_bubble_id", bubble_id, 1'b0);

    // Forwarding priorities
    tick(); idle(); id_valid = 1'b1; id_rs1 = 5'd5; id_use_rs1 = 1'b1;
    ex_valid = 1'b1; ex_w_rd = 1'b1; ex_rd = 5'd5;
    settle(); chk("fwd_ex", fwd_op1, 2'd1); chk("fwd_ex_no_stall", stall_id, 1'b0);
    tick(); idle(); id_valid = 1'b1; id_rs1 = 5'd5; id_use_rs1 = 1'b1;
    mem_valid = 1'b1; mem_w_rd = 1'b1; mem_rd = 5'd5;
    settle(); chk("fwd_mem", fwd_op1, 2'd2);
    ex_valid = 1'b1; ex_w_rd = 1'b1; ex_rd = 5'd5;
    settle(); chk("fwd_ex_over_mem", fwd_op1, 2'd1);
    tick(); idle(); id_valid = 1'b1; id_rs2 = 5'd5; id_use_rs2 = 1'b1;
    wb_valid = 1'b1; wb_w_rd = 1'b1; wb_rd = 5'd5;
    settle(); chk("fwd_wb", fwd_op2, 2'd3);
    tick(); idle(); id_valid = 1'b1; id_rs2 = 5'd0; id_use_rs2 = 1'b1;
    ex_valid = 1'b1; ex_w_rd = 1'b1; ex_rd = 5'd0;
    settle(); chk("fwd_x0", fwd_op2, 2'd0);

    // Load-use: one stall cycle, then forward from MEM
    tick(); idle(); id_valid = 1'b1; id_rs1 = 5'd7; id_use_rs1 = 1'b1;
    ex_valid = 1'b1; ex_is_load = 1'b1; ex_w_rd = 1'b1; ex_rd = 5'd7;
    settle(); chk("lu_stall_if", stall_if, 1'b1); chk("lu_stall_id", stall_id, 1'b1);
    chk("lu_bubble_ex", bubble_ex, 1'b1); chk("lu_fwd_none", fwd_op1, 2'd0);
    tick(); idle(); id_valid = 1'b1; id_rs1 = 5'd7; id_use_rs1 = 1'b1;
    mem_valid = 1'b1; mem_w_rd = 1'b1; mem_rd = 5'd7; dmem_req = 1'b1; dmem_ack = 1'b1;
    settle(); chk("lu_next_fwd", fwd_op1, 2'd2); chk("lu_next_stall", stall_id, 1'b0);

    // Multi-cycle op: MC_LAT-1 stall cycles, then EX advances
    tick(); idle(); ex_valid = 1'b1; ex_mc_start = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) tick();
      settle();
      chk($sformatf("mc_stall_ex_%0d", k), stall_ex, (k < 3) ? 1'b1 : 1'b0);
      chk($sformatf("mc_bubble_mem_%0d", k), bubble_mem, (k < 3) ? 1'b1 : 1'b0);
    end

    // Multi-cycle op with three MEM-wait cycles: busy period stretches by 3
    tick(); idle(); ex_valid = 1'b1; ex_mc_start = 1'b1;
    for (int c = 0; c < 7; c++) begin
      if (c > 0) tick();
      mem_valid = 1'b1; dmem_req = (c >= 1 && c <= 3); dmem_ack = !(c >= 1 && c <= 3);
      settle();
      chk($sformatf("mcw_stall_ex_%0d", c), stall_ex, (c < 6) ? 1'b1 : 1'b0);
      if (c == 2) begin
        chk("mcw_stall_mem", stall_mem, 1'b1);
        chk("mcw_bubble_wb", bubble_wb, 1'b1);
        chk("mcw_bubble_mem", bubble_mem, 1'b0);
      end
      if (c == 4) chk("mcw_busy_bubble_mem", bubble_mem, 1'b1);
    end

    // Taken branch while fetch waits two cycles
    tick(); idle(); imem_ready = 1'b0; ex_valid = 1'b1; ex_branch = 1'b1; ex_branch_dest = 32'h100;
    settle(); chk("br_redirect0", redirect, 1'b0); chk("br_bubble_id0", bubble_id, 1'b1);
    chk("br_bubble_ex0", bubble_ex, 1'b1);
    tick(); idle(); imem_ready = 1'b0;
    settle(); chk("br_redirect1", redirect, 1'b0); chk("br_bubble_id1", bubble_id, 1'b1);
    chk("br_stall_if1", stall_if, 1'b1);
    tick(); idle();
    settle(); chk("br_redirect2", redirect, 1'b1); chk("br_pc2", redirect_pc, 32'h100);
    chk("br_bubble_id2", bubble_id, 1'b1);
    tick(); idle();
    settle(); chk("br_redirect3", redirect, 1'b0); chk("br_bubble_id3", bubble_id, 1'b0);

    // A second branch overwrites the parked target
    tick(); idle(); imem_ready = 1'b0; ex_valid = 1'b1; ex_branch = 1'b1; ex_branch_dest = 32'h200;
    tick(); idle(); imem_ready = 1'b0; ex_valid = 1'b1; ex_branch = 1'b1; ex_branch_dest = 32'h300;
    tick(); idle();
    settle(); chk("ovw_redirect", redirect, 1'b1); chk("ovw_pc", redirect_pc, 32'h300);

    // Branch wins over a same-cycle load-use
    tick(); idle(); id_valid = 1'b1; id_rs1 = 5'd7; id_use_rs1 = 1'b1;
    ex_valid = 1'b1; ex_branch = 1'b1; ex_branch_dest = 32'h40;
    ex_is_load = 1'b1; ex_w_rd = 1'b1; ex_rd = 5'd7;
    settle(); chk("brlu_stall_id", stall_id, 1'b0); chk("brlu_stall_if", stall_if, 1'b0);
    chk("brlu_bubble_id", bubble_id, 1'b1); chk("brlu_bubble_ex", bubble_ex, 1'b1);
    chk("brlu_redirect", redirect, 1'b1); chk("brlu_pc", redirect_pc, 32'h40);

    // Reset in the middle of a multi-cycle op
    tick(); idle(); ex_valid = 1'b1; ex_mc_start = 1'b1;
    tick(); #2; rst = 1'b1; #1;
    chk("rstbusy_stall_ex", stall_ex, 1'b0); chk("rstbusy_bubble_mem", bubble_mem, 1'b1);
    tick(); rst = 1'b0; idle();
    settle(); chk("rstbusy_after_stall", stall_ex, 1'b0); chk("rstbusy_after_bmem", bubble_mem, 1'b0);

    // Reset while a redirect is parked
    tick(); idle(); imem_ready = 1'b0; ex_valid = 1'b1; ex_branch = 1'b1; ex_branch_dest = 32'h500;
    tick(); idle(); imem_ready = 1'b0; #2; rst = 1'b1;
    tick(); rst = 1'b0; idle();
    settle(); chk("rstpend_redirect", redirect, 1'b0); chk("rstpend_bubble_id", bubble_id, 1'b0);

    // Mixed traffic checked only by the model
    for (int n = 0; n < 200; n++) begin
      tick(); idle();
      id_valid = 1'($urandom_range(0, 1)); id_rs1 = 5'($urandom_range(0, 3));
      id_rs2 = 5'($urandom_range(0, 3)); id_use_rs1 = 1'($urandom_range(0, 1));
      id_use_rs2 = 1'($urandom_range(0, 1));
      ex_valid = 1'($urandom_range(0, 1)); ex_w_rd = 1'($urandom_range(0, 1));
      ex_is_load = 1'($urandom_range(0, 1)); ex_rd = 5'($urandom_range(0, 3));
      ex_branch = ($urandom_range(0, 3) == 0); ex_branch_dest = $urandom;
      mem_valid = 1'($urandom_range(0, 1)); mem_w_rd = 1'($urandom_range(0, 1));
      mem_rd = 5'($urandom_range(0, 3));
      wb_valid = 1'($urandom_range(0, 1)); wb_w_rd = 1'($urandom_range(0, 1));
      wb_rd = 5'($urandom_range(0, 3));
      imem_ready = ($urandom_range(0, 3) != 0); dmem_req = 1'($urandom_range(0, 1));
      dmem_ack = ($urandom_range(0, 2) != 0);
    end

    tick(); idle();
    settle();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Central stall/flush/forwarding controller for the 5-stage IF/ID/EX/MEM/WB pipeline.
- Consumes per-stage register/valid summaries plus the imem/dmem handshakes.
- Produces per-stage stall (hold) and bubble (insert NOP) strobes, operand forwarding selects, and the fetch redirect.
- Sequences multi-cycle EX ops and holds pending redirects across imem wait.

Parameters:
MC_LAT, 4, total cycles a multi-cycle op occupies EX (≥1; 1 = no stall)
XLEN, 32, address width of redirect_pc/ex_branch_dest

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
id_valid  in  1  ID holds a non-bubble instr
id_rs1, id_rs2  in  5  ID source regs
id_use_rs1, id_use_rs2  in  1  source actually read
ex_valid, ex_w_rd, ex_is_load, ex_mc_start  in  1  EX stage flags; mc_start = multi-cycle op in EX
ex_rd  in  5  EX dest
ex_branch  in  1  EX resolved taken branch/jump
ex_branch_dest  in  XLEN  target
mem_valid, mem_w_rd  in  1; mem_rd  in  5
wb_valid, wb_w_rd  in  1; wb_rd  in  5
imem_ready  in  1  fetch data valid this cycle
dmem_req, dmem_ack  in  1  MEM access request / completion
stall_if, stall_id, stall_ex, stall_mem  out  1  hold stage register
bubble_id, bubble_ex, bubble_mem, bubble_wb  out  1  load bubble into stage register
fwd_op1, fwd_op2  out  2  0 regfile, 1 EX, 2 MEM, 3 WB
redirect  out  1  load PC from redirect_pc
redirect_pc  out  XLEN  new fetch PC

Behaviour:
- rst asserted: state=RUN, mc_cnt=0, rd_pend=0, rd_pc_q=0.
- While rst is asserted, outputs are forced to: stalls 0, all bubbles 1, fwd 0, redirect 0, redirect_pc 0.
- Priority, highest first: MEM_WAIT > EX_BUSY > branch > load-use > imem wait.
- MEM_WAIT (comb): mem_valid & dmem_req & !dmem_ack.
  - Outputs: stall_if/id/ex/mem=1, bubble_wb=1.
  - Freezes mc_cnt. Branch/load-use are not acted on.
- FSM RUN→EX_BUSY: ex_valid & ex_mc_start & MC_LAT>1 & !MEM_WAIT; mc_cnt←MC_LAT-2.
- EX_BUSY outputs: stall_if/id/ex=1, bubble_mem=1.
- EX_BUSY counting: mc_cnt decrements each non-MEM_WAIT cycle. Return to RUN when mc_cnt==0; EX advances on the following cycle.
- Net effect: an op entering EX at cycle t leaves EX at t+MC_LAT.
- Branch take: ex_valid & ex_branch & !stall_ex.
  - bubble_id=1, bubble_ex=1 (squash IF and ID instrs).
  - Any same-cycle load-use stall is cancelled.
  - If imem_ready: redirect=1, redirect_pc=ex_branch_dest for that cycle.
  - Else: rd_pend←1, rd_pc_q←dest.
- Pending redirect: while rd_pend, redirect_pc=rd_pc_q and bubble_id=1 (in-flight fetch is stale).
  - redirect=1 on the first cycle imem_ready=1, then rd_pend←0.
  - A new branch take while rd_pend overwrites rd_pc_q.
- Load-use: ex_valid & ex_is_load & ex_w_rd & ex_rd!=0 & id_valid & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
  - Outputs: stall_if=1, stall_id=1, bubble_ex=1. Lasts exactly one cycle per load.
- Imem wait: !imem_ready & not stalled → bubble_id=1, stall_if=1.
- Forwarding, per operand:
  - EX match (valid, w_rd, rd!=0, rd==rs, !ex_is_load) → 1; else MEM match → 2; else WB match → 3; else 0.
  - rs==0 always 0. Selects are valid regardless of stall.
- Invariant: a stage never sees stall and bubble together; stall wins.
- Reset mid EX_BUSY or mid pending redirect aborts it: FSM→RUN, pending cleared.

Decomposition:
- pipeline_pkg gains: fwd_sel_t enum (FWD_RF, FWD_EX, FWD_MEM, FWD_WB), hz_state_t enum (HZ_RUN, HZ_EX_BUSY).
- One sub-module: fwd_unit, a combinational per-operand priority comparator, instantiated twice.
- FSM, counter, redirect latch and stall/bubble priority logic live in hazard_ctrl.

Test Plan:
- Back-to-back ALU ops: EX writes x5, ID reads rs1=x5 → fwd_op1=1. Same with MEM writing x5 → 2. ID rs2=x0 with EX rd=x0 → fwd_op2=0.
- Load x7 in EX, ID uses x7 → one cycle of stall_if/id=1, bubble_ex=1. Next cycle (load in MEM) → fwd=2, no stall.
- MC_LAT=4, ex_mc_start at cycle 10 → stall_ex=1 for cycles 10-12, bubble_mem=1 for cycles 10-12, EX advances at cycle 13.
- dmem_ack held low 3 cycles during that EX_BUSY → all stalls held, mc_cnt frozen, EX_BUSY extends by 3 cycles.
- Taken branch, dest 0x100, imem_ready=0 for 2 cycles → redirect=0 then; on the ready cycle redirect=1 with redirect_pc=0x100. bubble_id=1 throughout.
- Branch and load-use in the same cycle → no stall, bubble_id/ex=1. rst asserted mid EX_BUSY → state RUN, outputs at reset values.
